// File: rtl/mem_access_unit.sv
// mem_access_unit
//   MEM-stage data memory. Performs byte/half/word stores, loads with sign
//   or zero extension, and a handshaked memory dump for the debug unit.
//
//   Parameters:
//     BUS_SIZE      data width; the byte-lane logic assumes 32
//     MEM_ADDR_SIZE word-address width, depth = 2**MEM_ADDR_SIZE words
//
//   Ports:
//     i_clk, i_reset (async, active-high)
//     i_enable        pipeline advance, also aborts a dump in progress
//     i_mem_rd_src    load format  (LB, LBU, LH, LHU, LW)
//     i_mem_wr_src    store format (SB, SH, SW)
//     i_mem_write     store request
//     i_mem_to_reg    load request, gates o_mem_rd_data
//     i_bus_b         store data
//     i_alu_result    byte address
//     o_mem_rd_data   formatted load data (combinational)
//     o_misaligned    current access misaligned (trap build only)
//     i_dump_start, i_dump_ready, o_dump_valid, o_dump_addr, o_dump_data,
//     o_dump_done, o_busy   memory dump port
//
//   Build option:
//     MEM_ACCESS_MISALIGN_TRAP_EN  defined: misaligned accesses are flagged,
//       misaligned stores are dropped and misaligned loads return 0.
//       undefined: low offset bits are cleared to the access size.
//
//   Dump FSM:
//     state | meaning
//     IDLE  | normal operation, stores allowed
//     SEND  | presenting mem[o_dump_addr], waiting for i_dump_ready
//     DONE  | last word accepted, o_dump_done pulsing

module mem_access_unit #(
  parameter int BUS_SIZE      = 32,
  parameter int MEM_ADDR_SIZE = 8
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_enable,
  input  logic [2:0]               i_mem_rd_src,
  input  logic [1:0]               i_mem_wr_src,
  input  logic                     i_mem_write,
  input  logic                     i_mem_to_reg,
  input  logic [BUS_SIZE-1:0]      i_bus_b,
  input  logic [BUS_SIZE-1:0]      i_alu_result,
  output logic [BUS_SIZE-1:0]      o_mem_rd_data,
  output logic                     o_misaligned,
  input  logic                     i_dump_start,
  input  logic                     i_dump_ready,
  output logic                     o_dump_valid,
  output logic [MEM_ADDR_SIZE-1:0] o_dump_addr,
  output logic [BUS_SIZE-1:0]      o_dump_data,
  output logic                     o_dump_done,
  output logic                     o_busy
);

  localparam int DEPTH = 2 ** MEM_ADDR_SIZE;
  localparam logic [MEM_ADDR_SIZE-1:0] LAST_IDX = '1;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_DONE} state_t;

  state_t state;
  logic [BUS_SIZE-1:0] mem [DEPTH];

  logic [MEM_ADDR_SIZE-1:0] idx;
  logic [MEM_ADDR_SIZE-1:0] dump_next;
  logic [1:0]               raw_off, ld_off, st_off;
  logic                     ld_half, ld_word, st_half, st_word;
  logic                     ld_mis, st_mis;
  logic                     unused_addr;

  assign idx         = i_alu_result[MEM_ADDR_SIZE+1:2];
  assign raw_off     = i_alu_result[1:0];
  assign unused_addr = ^i_alu_result[BUS_SIZE-1:MEM_ADDR_SIZE+2];
  assign dump_next   = o_dump_addr + MEM_ADDR_SIZE'(1);

  assign ld_word = i_mem_rd_src[2];
  assign ld_half = ~i_mem_rd_src[2] & i_mem_rd_src[1];
  assign st_word = i_mem_wr_src[1];
  assign st_half = (i_mem_wr_src == 2'b01);

`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
  assign ld_mis       = i_mem_to_reg & ((ld_half & raw_off[0]) | (ld_word & |raw_off));
  assign st_mis       = i_mem_write  & ((st_half & raw_off[0]) | (st_word & |raw_off));
  assign ld_off       = raw_off;
  assign st_off       = raw_off;
  assign o_misaligned = ld_mis | st_mis;
`else
  // Drop offset bits below the access size so lane selection stays aligned.
  assign ld_off       = ld_word ? 2'b00 : (ld_half ? {raw_off[1], 1'b0} : raw_off);
  assign st_off       = st_word ? 2'b00 : (st_half ? {raw_off[1], 1'b0} : raw_off);
  assign ld_mis       = 1'b0;
  assign st_mis       = 1'b0;
  assign o_misaligned = 1'b0;
`endif

  // Load path: combinational read, so a same-cycle store is not yet visible.
  logic [BUS_SIZE-1:0] rd_word;
  logic [7:0]          ld_byte;
  logic [15:0]         ld_hw;

  assign rd_word = mem[idx];

  always_comb begin
    ld_byte = rd_word[7:0];
    case (ld_off)
      2'd1:    ld_byte = rd_word[15:8];
      2'd2:    ld_byte = rd_word[23:16];
      2'd3:    ld_byte = rd_word[31:24];
      default: ld_byte = rd_word[7:0];
    endcase
    ld_hw = ld_off[1] ? rd_word[31:16] : rd_word[15:0];

    case (i_mem_rd_src)
      3'b000:  o_mem_rd_data = {{(BUS_SIZE-8){ld_byte[7]}}, ld_byte};
      3'b001:  o_mem_rd_data = {{(BUS_SIZE-8){1'b0}}, ld_byte};
      3'b010:  o_mem_rd_data = {{(BUS_SIZE-16){ld_hw[15]}}, ld_hw};
      3'b011:  o_mem_rd_data = {{(BUS_SIZE-16){1'b0}}, ld_hw};
      default: o_mem_rd_data = rd_word;
    endcase
    if (!i_mem_to_reg || ld_mis) o_mem_rd_data = '0;
  end

  // Store path: replicate data onto all lanes, byte enables pick the lanes.
  logic [3:0]          st_be;
  logic [BUS_SIZE-1:0] st_data;
  logic                st_en;

  always_comb begin
    case (i_mem_wr_src)
      2'b00: begin
        st_be   = 4'b0001 << st_off;
        st_data = {4{i_bus_b[7:0]}};
      end
      2'b01: begin
        st_be   = st_off[1] ? 4'b1100 : 4'b0011;
        st_data = {2{i_bus_b[15:0]}};
      end
      default: begin
        st_be   = 4'b1111;
        st_data = i_bus_b;
      end
    endcase
  end

  // Stores are held off for the whole dump so the dumped image is consistent.
  assign st_en = i_mem_write & i_enable & (state == ST_IDLE) & ~st_mis;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (st_en) begin
      for (int l = 0; l < 4; l++)
        if (st_be[l]) mem[idx][8*l +: 8] <= st_data[8*l +: 8];
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state        <= ST_IDLE;
      o_dump_valid <= 1'b0;
      o_dump_addr  <= '0;
      o_dump_data  <= '0;
      o_dump_done  <= 1'b0;
      o_busy       <= 1'b0;
    end else begin
      o_dump_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_dump_start && !i_enable) begin
            state        <= ST_SEND;
            o_dump_valid <= 1'b1;
            o_dump_addr  <= '0;
            o_dump_data  <= mem['0];
            o_busy       <= 1'b1;
          end
        end
        ST_SEND: begin
          if (i_enable) begin
            // Pipeline resumed: abandon the dump without a done pulse.
            state        <= ST_IDLE;
            o_dump_valid <= 1'b0;
            o_dump_addr  <= '0;
            o_dump_data  <= '0;
            o_busy       <= 1'b0;
          end else if (i_dump_ready) begin
            o_dump_addr <= dump_next;
            if (o_dump_addr == LAST_IDX) begin
              state        <= ST_DONE;
              o_dump_valid <= 1'b0;
              o_dump_done  <= 1'b1;
            end else begin
              o_dump_data <= mem[dump_next];
            end
          end
        end
        ST_DONE: begin
          state       <= ST_IDLE;
          o_dump_addr <= '0;
          o_busy      <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
MEM-stage consumer of the EX/MEM pipeline register outputs. Holds the data memory and performs byte, half and word stores. Performs loads with sign or zero extension. Provides a handshaked memory-dump port for the debug unit, usable while the pipeline is halted. Output feeds the MEM/WB register.

Parameters:
BUS_SIZE, 32, data bus width in bits; fixed at 32 for byte-lane logic.
MEM_ADDR_SIZE, 8, word-address width; memory depth = 2**MEM_ADDR_SIZE words.

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous, active-high reset
i_enable  in  1  pipeline advance; stores commit only when high
i_mem_rd_src  in  3  load format: 000 LB, 001 LBU, 010 LH, 011 LHU, 100 LW; 101-111 treated as LW
i_mem_wr_src  in  2  store format: 00 SB, 01 SH, 10/11 SW
i_mem_write  in  1  store request
i_mem_to_reg  in  1  load request; gates o_mem_rd_data
i_bus_b  in  BUS_SIZE  store data
i_alu_result  in  BUS_SIZE  byte address
o_mem_rd_data  out  BUS_SIZE  formatted load data
o_misaligned  out  1  current access misaligned (see Optional Feature)
i_dump_start  in  1  one-cycle request to start a memory dump
i_dump_ready  in  1  dump consumer ready
o_dump_valid  out  1  dump word valid
o_dump_addr  out  MEM_ADDR_SIZE  word index of dump word
o_dump_data  out  BUS_SIZE  dump word
o_dump_done  out  1  one-cycle pulse after last word accepted
o_busy  out  1  dump FSM not IDLE

Behaviour:
- Addressing: word index = i_alu_result[MEM_ADDR_SIZE+1:2]; byte offset = i_alu_result[1:0]; upper bits ignored (address wraps modulo depth).
- Reset: all memory words = 0; FSM = IDLE; o_dump_valid = 0, o_dump_addr = 0, o_dump_data = 0, o_dump_done = 0, o_busy = 0. With the memory cleared, o_mem_rd_data = 0.
- Store: commits at the posedge when i_mem_write & i_enable & FSM == IDLE & store not suppressed.
  - SB writes byte lane = offset with i_bus_b[7:0].
  - SH writes lanes {offset[1],0} and {offset[1],1} with i_bus_b[15:0].
  - SW writes the full word.
  - Untouched lanes keep their value.
- Load: combinational read of the current word. Output is valid in the same cycle the address is presented.
  - LB/LBU select the byte at offset; LH/LHU select the half at offset[1].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - o_mem_rd_data = 0 when i_mem_to_reg = 0.
- Same-cycle store and load to the same word: the load returns the old data (write lands at the clock edge).
- Dump FSM states: IDLE, SEND, DONE.
  - IDLE -> SEND on i_dump_start & ~i_enable; o_dump_addr = 0. i_dump_start is ignored while i_enable = 1.
  - SEND: o_dump_valid = 1, o_dump_data = mem[o_dump_addr].
    - Handshake completes on o_dump_valid & i_dump_ready.
    - On completion, o_dump_addr increments.
    - On completion at the last index (2**MEM_ADDR_SIZE-1), go to DONE.
    - o_dump_data and o_dump_addr are held stable while i_dump_ready = 0.
  - DONE: o_dump_done = 1 for one cycle, then IDLE; o_dump_addr returns to 0.
  - Abort: if i_enable rises in SEND, next state is IDLE. o_dump_valid drops, no o_dump_done pulse, o_dump_addr = 0.
  - i_dump_start while in SEND or DONE is ignored.
- Stores are blocked while o_busy = 1. The pipeline is expected to be halted at that point, but memory integrity is guaranteed regardless.
- Reset mid-dump: immediate return to reset state.

Optional Feature:
Macro MEM_ACCESS_MISALIGN_TRAP_EN.
- Defined:
  - o_misaligned = 1 for LH/LHU/SH with offset[0] = 1, or LW/SW with offset != 0.
  - Qualifying conditions: an active request (i_mem_write or i_mem_to_reg).
  - A misaligned store is suppressed; a misaligned load returns 0.
- Undefined:
  - Offset bits below the access size are forced to 0 (half -> offset[0] = 0; word -> offset = 0) before lane selection.
  - o_misaligned is tied to 0.

Test Plan:
- Reset, then LW at 0x00 -> 0x00000000; SW 0xDEADBEEF at 0x04 with i_enable = 1, then LW at 0x04 -> 0xDEADBEEF.
- SB 0x80 at 0x05, then:
  - LB at 0x05 -> 0xFFFFFF80; LBU at 0x05 -> 0x00000080; LW at 0x04 -> 0xDEAD80EF.
- SH 0x8001 at 0x06, then:
  - LH at 0x06 -> 0xFFFF8001; LHU -> 0x00008001.
  - SW with i_enable = 0 -> memory unchanged.
- With i_enable = 0, MEM_ADDR_SIZE = 2, words preloaded 1, 2, 3, 4, pulse i_dump_start with i_dump_ready toggling every other cycle:
  - 4 handshakes at addr 0..3 with data 1..4; data stable during stalls; o_dump_done pulses once; o_busy clears.
- Start a dump, accept 2 words, raise i_enable:
  - FSM returns to IDLE, no o_dump_done pulse.
  - A following SW at 0x00 commits.
- With MEM_ACCESS_MISALIGN_TRAP_EN defined, SW 0x12345678 at 0x02:
  - o_misaligned = 1, memory unchanged.
- With the macro undefined, the same store:
  - Writes word 0; LW at 0x00 -> 0x12345678.
